// File: rtl/ddr_axi_pkg.sv
// Shared definitions for the DDR3 AXI write-port logic: FSM state encodings
// and AXI field widths.
package ddr_axi_pkg;

  localparam int CTRL_ADDR_WIDTH_DFLT = 28;
  localparam int MEM_DQ_WIDTH_DFLT    = 32;
  localparam int AXI_LEN_W            = 4;

  localparam logic [AXI_LEN_W-1:0] BURST_LEN_16 = 4'hf;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_ADDR = 3'b010,
    S_DATA = 3'b100
  } state_t;

endpackage

// File: rtl/axi_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: the first requester above the previous
// owner (wrapping) wins; sel is one-hot, or zero when nobody requests.
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  output logic [NUM_REQ-1:0] sel
);

  int  last_idx;
  logic found;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    sel      = '0;
    found    = 1'b0;
    last_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last[i]) last_idx = i;
    end
    // Offsets 1..NUM_REQ visit every requester once, the previous owner last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == (last_idx + k) % NUM_REQ)) begin
          sel[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin sharing of the DDR3 AXI write port among NUM_REQ requesters;
// whole bursts are serialised and each burst's beat count is checked.
module axi_wr_arbiter
  import ddr_axi_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int CTRL_ADDR_WIDTH = CTRL_ADDR_WIDTH_DFLT,
  parameter int MEM_DQ_WIDTH    = MEM_DQ_WIDTH_DFLT
) (
  input  logic                                core_clk,
  input  logic                                ddr_rst,
  input  logic                                ddr_init_done,
  input  logic [NUM_REQ*CTRL_ADDR_WIDTH-1:0]  req_awaddr,
  input  logic [NUM_REQ*AXI_LEN_W-1:0]        req_awlen,
  input  logic [NUM_REQ-1:0]                  req_awvalid,
  output logic [NUM_REQ-1:0]                  req_awready,
  input  logic [NUM_REQ*MEM_DQ_WIDTH*8-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                  req_wready,
  output logic [NUM_REQ-1:0]                  req_wlast,
  output logic [CTRL_ADDR_WIDTH-1:0]          axi_awaddr,
  output logic [AXI_LEN_W-1:0]                axi_awlen,
  output logic                                axi_awvalid,
  input  logic                                axi_awready,
  output logic [MEM_DQ_WIDTH*8-1:0]           axi_wdata,
  input  logic                                axi_wready,
  input  logic                                axi_wusero_last,
  output logic [NUM_REQ-1:0]                  grant,
  output logic                                len_err
);

  localparam int DW = MEM_DQ_WIDTH * 8;
  localparam logic [NUM_REQ-1:0] LAST_GRANT_RST = {1'b1, {(NUM_REQ-1){1'b0}}};

  state_t                 state;
  logic [NUM_REQ-1:0]     last_grant;
  logic [NUM_REQ-1:0]     sel;
  logic [AXI_LEN_W-1:0]   beat_cnt;
  logic [CTRL_ADDR_WIDTH-1:0] sel_addr;
  logic [AXI_LEN_W-1:0]   sel_len;
  logic [DW-1:0]          grant_wdata;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req  (req_awvalid & {NUM_REQ{ddr_init_done}}),
    .last (last_grant),
    .sel  (sel)
  );

  always_comb begin
    sel_addr    = '0;
    sel_len     = '0;
    grant_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel[i]) begin
        sel_addr = req_awaddr[i*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH];
        sel_len  = req_awlen[i*AXI_LEN_W +: AXI_LEN_W];
      end
      if (grant[i]) grant_wdata = req_wdata[i*DW +: DW];
    end
  end

  // Handshakes are steered to the owner only, with no added latency.
  assign req_awready = (state == S_ADDR && axi_awvalid && axi_awready) ? grant : '0;
  assign req_wready  = (state == S_DATA && axi_wready)      ? grant : '0;
  assign req_wlast   = (state == S_DATA && axi_wusero_last) ? grant : '0;
  assign axi_wdata   = (state == S_DATA) ? grant_wdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge core_clk) begin
    if (ddr_rst) begin
      state       <= S_IDLE;
      axi_awvalid <= 1'b0;
      axi_awaddr  <= '0;
      axi_awlen   <= '0;
      grant       <= '0;
      len_err     <= 1'b0;
      beat_cnt    <= '0;
      last_grant  <= LAST_GRANT_RST;
    end else begin
      case (state)
        S_IDLE: begin
          if (|sel) begin
            grant       <= sel;
            axi_awaddr  <= sel_addr;
            axi_awlen   <= sel_len;
            axi_awvalid <= 1'b1;
            state       <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (axi_awvalid && axi_awready) begin
            axi_awvalid <= 1'b0;
            beat_cnt    <= '0;
            state       <= S_DATA;
          end
        end
        S_DATA: begin
          if (axi_wready) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (axi_wusero_last) begin
              // beat_cnt still holds this beat's zero-based index here.
              if (beat_cnt != axi_awlen) len_err <= 1'b1;
              last_grant <= grant;
              grant      <= '0;
              state      <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
